// File: rtl/imm_ext_pkg.sv
// Shared definitions for the MIPS immediate-extension blocks: mode encodings
// and default operand widths.
package imm_ext_pkg;

    localparam logic [1:0] IMM_ZEXT  = 2'b00;
    localparam logic [1:0] IMM_SEXT  = 2'b01;
    localparam logic [1:0] IMM_BROFF = 2'b10;
    localparam logic [1:0] IMM_LUI   = 2'b11;

    localparam int IMM_IN_W  = 16;
    localparam int IMM_OUT_W = 32;
    localparam int IMM_TAG_W = 5;

    typedef logic [1:0] imm_mode_t;

endpackage

// File: rtl/imm_ext_comb.sv
// Combinational immediate extension: zero-, sign-, branch-offset and
// load-upper forms. Shared with the single-cycle datapath.
module imm_ext_comb
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = IMM_IN_W,
    parameter int OUT_W = IMM_OUT_W
) (
    input  logic             en,
    input  imm_mode_t        mode,
    input  logic [IN_W-1:0]  imm,
    output logic [OUT_W-1:0] result
);

    // Branch offsets need two spare bits above the immediate for the <<2.
    if (OUT_W < IN_W + 2) begin : g_width_check
        $error("imm_ext_comb: OUT_W must be at least IN_W+2");
    end

    logic signed [OUT_W-1:0] sext;

    assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

    always_comb begin
        result = '0;
        if (en) begin
            case (mode)
                IMM_ZEXT:  result = {{(OUT_W-IN_W){1'b0}}, imm};
                IMM_SEXT:  result = sext;
                IMM_BROFF: result = sext <<< 2;
                IMM_LUI:   result = {imm, {(OUT_W-IN_W){1'b0}}};
                default:   result = '0;
            endcase
        end
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with valid/ready handshake, a main output
// register and one skid register so backpressure never loses a beat.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = IMM_IN_W,
    parameter int OUT_W = IMM_OUT_W,
    parameter int TAG_W = IMM_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             en,
    input  imm_mode_t        mode,
    input  logic [IN_W-1:0]  imm,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    if (OUT_W < IN_W + 2) begin : g_width_check
        $error("imm_extend_pipe: OUT_W must be at least IN_W+2");
    end

    logic [OUT_W-1:0] res_comb;
    logic             accept;
    logic             emit;

    // Main register (_p0) drives the outputs; skid register (_p1) catches
    // the beat accepted while the consumer stalls.
    logic [OUT_W-1:0] data_p0;
    logic [TAG_W-1:0] tag_p0;
    logic             vld_p0;
    logic [OUT_W-1:0] data_p1;
    logic [TAG_W-1:0] tag_p1;
    logic             vld_p1;

    imm_ext_comb #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_comb (
        .en     (en),
        .mode   (mode),
        .imm    (imm),
        .result (res_comb)
    );

    // in_ready comes straight from the skid flop, never from out_ready.
    assign in_ready  = !vld_p1;
    assign accept    = in_valid && in_ready && !flush;
    assign emit      = vld_p0 && out_ready;

    assign out_valid = vld_p0;
    assign out_data  = data_p0;
    assign out_tag   = tag_p0;

    // ---- stage boundary: result registered into main or skid ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            data_p0 <= '0;
            tag_p0  <= '0;
            data_p1 <= '0;
            tag_p1  <= '0;
        end else if (flush) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else if (vld_p1) begin
            if (emit) begin
                data_p0 <= data_p1;
                tag_p0  <= tag_p1;
                vld_p1  <= 1'b0;
            end
        end else if (vld_p0) begin
            if (emit && accept) begin
                data_p0 <= res_comb;
                tag_p0  <= in_tag;
            end else if (emit) begin
                vld_p0 <= 1'b0;
            end else if (accept) begin
                data_p1 <= res_comb;
                tag_p1  <= in_tag;
                vld_p1  <= 1'b1;
            end
        end else if (accept) begin
            data_p0 <= res_comb;
            tag_p0  <= in_tag;
            vld_p0  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: mode table, backpressure, streaming,
// flush and mid-operation reset.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        en;
    logic [1:0]  mode;
    logic [15:0] imm;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(
        .IN_W  (16),
        .OUT_W (32),
        .TAG_W (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .en        (en),
        .mode      (mode),
        .imm       (imm),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    typedef struct {
        logic        en;
        logic [1:0]  mode;
        logic [15:0] imm;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] i, input logic [4:0] t);
        in_valid = v;
        en       = 1'b1;
        mode     = m;
        imm      = i;
        in_tag   = t;
    endtask

    task automatic expect_out(input string name, input logic v, input logic [31:0] d, input logic [4:0] t);
        check({name, ".valid"}, 32'(out_valid), 32'(v));
        if (v) begin
            check({name, ".data"}, out_data, d);
            check({name, ".tag"}, 32'(out_tag), 32'(t));
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 2'b01, 16'hABCD, 5'd1, 32'hFFFFABCD};
        vecs[1] = '{1'b1, 2'b00, 16'hABCD, 5'd2, 32'h0000ABCD};
        vecs[2] = '{1'b1, 2'b10, 16'h0123, 5'd3, 32'h0000048C};
        vecs[3] = '{1'b1, 2'b10, 16'hFFFF, 5'd4, 32'hFFFFFFFC};
        vecs[4] = '{1'b1, 2'b11, 16'h0123, 5'd5, 32'h01230000};
        vecs[5] = '{1'b0, 2'b01, 16'hFFFF, 5'd6, 32'h00000000};
        vecs[6] = '{1'b1, 2'b10, 16'h8000, 5'd7, 32'hFFFE0000};
        vecs[7] = '{1'b1, 2'b11, 16'hFFFF, 5'd8, 32'hFFFF0000};
        vecs[8] = '{1'b1, 2'b01, 16'h7FFF, 5'd9, 32'h00007FFF};

        // Reset held with a beat offered: nothing may be taken.
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, 2'b01, 16'hFFFF, 5'd31);
        step();
        step();
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.data", out_data, 32'd0);
        check("rst.tag", 32'(out_tag), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        check("rst.nothing_accepted", 32'(out_valid), 32'd0);

        // Mode table, back to back with the consumer always ready.
        for (int k = 0; k < 9; k++) begin
            in_valid = 1'b1;
            en       = vecs[k].en;
            mode     = vecs[k].mode;
            imm      = vecs[k].imm;
            in_tag   = vecs[k].tag;
            step();
            expect_out($sformatf("vec%0d", k), 1'b1, vecs[k].exp, vecs[k].tag);
            check($sformatf("vec%0d.in_ready", k), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        expect_out("vec.drain", 1'b0, 32'd0, 5'd0);

        // Backpressure: A to main, B to skid, C held off.
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 16'h0001, 5'd1);
        step();
        expect_out("bp.A", 1'b1, 32'h1, 5'd1);
        check("bp.ready_after_A", 32'(in_ready), 32'd1);
        drive(1'b1, 2'b00, 16'h0002, 5'd2);
        step();
        check("bp.ready_after_B", 32'(in_ready), 32'd0);
        expect_out("bp.hold1", 1'b1, 32'h1, 5'd1);
        drive(1'b1, 2'b00, 16'h0003, 5'd3);
        step();
        step();
        check("bp.ready_full", 32'(in_ready), 32'd0);
        expect_out("bp.hold2", 1'b1, 32'h1, 5'd1);
        out_ready = 1'b1;
        step();
        expect_out("bp.emitB", 1'b1, 32'h2, 5'd2);
        check("bp.ready_reopen", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        expect_out("bp.emitC", 1'b1, 32'h3, 5'd3);
        step();
        expect_out("bp.empty", 1'b0, 32'd0, 5'd0);

        // Streaming: seven beats on seven consecutive cycles.
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 2'b00, 16'h0010 + 16'(k), 5'(k + 10));
            step();
            expect_out($sformatf("stream%0d", k), 1'b1, 32'h10 + 32'(k), 5'(k + 10));
            check($sformatf("stream%0d.in_ready", k), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        expect_out("stream.drain", 1'b0, 32'd0, 5'd0);

        // Flush with main and skid both full; D offered in the flush cycle.
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 16'h0005, 5'd5);
        step();
        drive(1'b1, 2'b00, 16'h0006, 5'd6);
        step();
        check("fl.full", 32'(in_ready), 32'd0);
        flush = 1'b1;
        drive(1'b1, 2'b00, 16'h0004, 5'd4);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl.valid", 32'(out_valid), 32'd0);
        check("fl.in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        step();
        check("fl.D_absent", 32'(out_valid), 32'd0);

        // Flush with only main full, so D sees in_ready=1 and is still dropped.
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 16'h0007, 5'd7);
        step();
        check("fl2.ready", 32'(in_ready), 32'd1);
        flush = 1'b1;
        drive(1'b1, 2'b00, 16'h0004, 5'd4);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("fl2.valid", 32'(out_valid), 32'd0);
        step();
        check("fl2.D_absent", 32'(out_valid), 32'd0);

        // Reset while full and out_ready toggling.
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 16'h0011, 5'd11);
        step();
        drive(1'b1, 2'b00, 16'h0012, 5'd12);
        step();
        out_ready = 1'b1;
        rst = 1'b1;
        step();
        out_ready = 1'b0;
        check("mrst.valid", 32'(out_valid), 32'd0);
        check("mrst.data", out_data, 32'd0);
        check("mrst.in_ready", 32'(in_ready), 32'd1);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 2'b01, 16'h8001, 5'd7);
        step();
        in_valid = 1'b0;
        expect_out("mrst.first", 1'b1, 32'hFFFF8001, 5'd7);
        step();
        expect_out("mrst.drain", 1'b0, 32'd0, 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
